output_interface: RTL

OUTPUT_INTERFACE -- requirements
Module: output_interface

---
 rtl/output_interface.sv | 66 ++++++
 1 files changed

// File: rtl/output_interface.sv
// output_interface: one-entry output buffer for a mesh router port, fed by a
// round-robin arbiter over the L, R, U, D and PE input interfaces.
module output_interface #(
  parameter int DATA_WIDTH = 64,
  parameter logic [4:0] DIRECTION = 5'b00001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqL,
  input  logic                  reqR,
  input  logic                  reqU,
  input  logic                  reqD,
  input  logic                  reqPE,
  input  logic [DATA_WIDTH-1:0] dataiL,
  input  logic [DATA_WIDTH-1:0] dataiR,
  input  logic [DATA_WIDTH-1:0] dataiU,
  input  logic [DATA_WIDTH-1:0] dataiD,
  input  logic [DATA_WIDTH-1:0] dataiPE,
  input  logic                  ro,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] datao,
  output logic                  clrL,
  output logic                  clrR,
  output logic                  clrU,
  output logic                  clrD,
  output logic                  clrPE
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0] state;
  logic [2:0] ptr, win, ptr_nxt;
  logic [4:0] req, clr;
  logic found, load;
  logic [DATA_WIDTH-1:0] data [5];
  // req bit 4 is L down to bit 0 PE, matching DIRECTION; ptr/win index 0 is L
  assign req = {reqL, reqR, reqU, reqD, reqPE} & ~DIRECTION;
  assign data = '{dataiL, dataiR, dataiU, dataiD, dataiPE};
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      if (req[3'(4 - (int'(ptr) + k) % 5)]) begin
        win = 3'((int'(ptr) + k) % 5);
        found = 1'b1;
      end
    end
  end
  assign load = rst & found & ((state == EMPTY) | ro);
  assign ptr_nxt = (win == 3'd4) ? 3'd0 : win + 3'd1;
  assign clr = load ? (5'b10000 >> win) : 5'b0;
  assign {clrL, clrR, clrU, clrD, clrPE} = clr;
  assign so = (state == FULL);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      datao <= '0;
      ptr   <= '0;
    end else if (load) begin
      state <= FULL;
      datao <= data[win];
      ptr   <= ptr_nxt;
    end else if (ro) begin
      state <= EMPTY;
    end
  end
endmodule
